// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall handling logic.
//   SYSCALL_*  : $v0 function codes recognised by the CPU. Only HALT is
//                acted on by syscall_unit; PRINT_INT / PRINT_HEX are
//                reserved for the display decode that lives elsewhere.
//   sc_state_e : run/halt state encoding of the syscall FSM.
package syscall_pkg;

  localparam int unsigned SYSCALL_PRINT_INT = 1;
  localparam int unsigned SYSCALL_HALT      = 10;
  localparam int unsigned SYSCALL_PRINT_HEX = 34;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } sc_state_e;

endpackage

// File: rtl/syscall_unit.sv
// syscall_unit: executes the MIPS-style `syscall` instruction for the
// single-cycle CPU.
//   A halt code on regSValue stops the CPU (enable=0) until an operator
//   resume pulse or a reset; any other code latches regTValue into the
//   display register that drives the board LEDs / 7-segment output.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   regSValue      in   syscall function code ($v0)
//   regTValue      in   syscall argument ($a0)
//   syscall        in   decoded instruction is a syscall (level)
//   continue_i     in   operator resume request; named with a suffix
//                       because `continue` is a SystemVerilog keyword
//   enable         out  CPU run enable (1 = run, 0 = halted), registered
//   syscallOutput  out  last displayed argument, registered
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_CODE  = DATA_WIDTH'(SYSCALL_HALT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] regSValue,
  input  logic [DATA_WIDTH-1:0] regTValue,
  input  logic                  syscall,
  input  logic                  continue_i,
  output logic                  enable,
  output logic [DATA_WIDTH-1:0] syscallOutput
);

  sc_state_e             state_q, state_d;
  logic                  enable_q, enable_d;
  logic [DATA_WIDTH-1:0] disp_q, disp_d;

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    case (state_q)
      ST_RUN: begin
        if (syscall) begin
          // Full-width compare: a code only matching in the low bits is
          // treated as a display request, not a halt.
          if (regSValue == HALT_CODE) state_d = ST_HALT;
          else                        disp_d  = regTValue;
        end
      end
      ST_HALT: begin
        // CPU is stalled, so syscall/register inputs are stale here;
        // only the resume pulse matters, which also prevents a re-halt
        // in the resume cycle.
        if (continue_i) state_d = ST_RUN;
      end
    endcase
    // Enable is registered from the next state so it changes on the
    // same edge as the state, with no input-to-output path.
    enable_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      enable_q <= 1'b1;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      disp_q   <= disp_d;
    end
  end

  assign enable        = enable_q;
  assign syscallOutput = disp_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: the stimulus process applies one
// input vector per cycle and pushes the response a behavioural model
// expects after that edge; the monitor pops and compares after each edge.
module tb_syscall_unit;

  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] regSValue = '0;
  logic [DW-1:0] regTValue = '0;
  logic          syscall = 1'b0;
  logic          continue_i = 1'b0;
  logic          enable;
  logic [DW-1:0] syscallOutput;

  syscall_unit #(.DATA_WIDTH(DW), .HALT_CODE(32'h0000_000A)) dut (
    .clock(clock),
    .reset(reset),
    .regSValue(regSValue),
    .regTValue(regTValue),
    .syscall(syscall),
    .continue_i(continue_i),
    .enable(enable),
    .syscallOutput(syscallOutput)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          en;
    logic [DW-1:0] out;
    int            id;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  // Reference model: CPU halted flag and display value.
  bit          m_halted = 1'b0;
  logic [DW-1:0] m_disp = '0;
  int          cyc_id = 0;

  task automatic cyc(input bit rst, input bit sc, input logic [DW-1:0] code,
                     input logic [DW-1:0] arg, input bit cont);
    exp_t e;
    @(negedge clock);
    reset      = rst;
    syscall    = sc;
    regSValue  = code;
    regTValue  = arg;
    continue_i = cont;
    if (rst) begin
      m_halted = 1'b0;
      m_disp   = '0;
    end else if (m_halted) begin
      if (cont) m_halted = 1'b0;
    end else if (sc) begin
      if (code == 32'd10) m_halted = 1'b1;
      else                m_disp   = arg;
    end
    e.en  = !m_halted;
    e.out = m_disp;
    e.id  = cyc_id;
    cyc_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected response per edge after it was queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (enable !== e.en) begin
          errors++;
          $display("FAIL enable cyc=%0d actual=%b required=%b", e.id, enable, e.en);
        end
        checks++;
        if (syscallOutput !== e.out) begin
          errors++;
          $display("FAIL syscallOutput cyc=%0d actual=%h required=%h",
                   e.id, syscallOutput, e.out);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] code;
    int sel;
    // Reset, single-cycle display, halt and hold.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 100, 0);
    cyc(0, 1, 10, 0, 0);
    repeat (6) cyc(0, 0, 0, 0, 0);
    // Inputs ignored while halted.
    cyc(0, 1, 3, 999, 0);
    // Resume, then multi-cycle display.
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 1, 2, 200, 0);
    // continue ignored in RUN.
    cyc(0, 0, 0, 0, 1);
    // Reset during halt.
    cyc(0, 1, 10, 5, 0);
    cyc(1, 1, 10, 0, 0);
    cyc(0, 1, 10, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    // Priority: continue beats a simultaneous halt syscall.
    cyc(0, 1, 10, 0, 0);
    cyc(0, 1, 10, 7, 1);
    cyc(0, 0, 0, 0, 0);
    // Full-width compare: these are display requests, not halts.
    cyc(0, 1, 32'h8000_000A, 32'hDEAD_BEEF, 0);
    cyc(0, 1, 32'h0001_000A, 32'h1234_5678, 0);
    cyc(0, 1, 32'h0000_000B, 32'hCAFE_F00D, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1:    code = 32'd10;
        2:       code = 32'd1;
        3:       code = 32'd34;
        4:       code = 32'd10 | (32'd1 << $urandom_range(4, 31));
        default: code = $urandom();
      endcase
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 1), code, $urandom(),
          ($urandom_range(0, 4) == 0));
    end
    cyc(0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    repeat (5) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=%0d checks required=completion", checks);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
